// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   hz_state_e : controller context (RUN / FLUSH / FREEZE)
//   fwd_sel_e  : EX operand source select (regfile / MEM alu_out / WB mux out)
//   Scoreboard layout: one entry per stage (EX, MEM, WB), each {vld, ld, addr}.
package hazard_fwd_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FREEZE = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Scoreboard entry fields: one valid flag, one load flag, then the address.
    localparam int SB_VLD_W = 1;
    localparam int SB_LD_W  = 1;

    // Scoreboard depth and stage slots.
    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    // Remaining-flush-cycle counter; FLUSH_CYC is limited to 1..3.
    localparam int FLUSH_CNT_W = 2;

endpackage

// File: rtl/hazard_fwd_unit_sb_stage.sv
// hz_sb_stage: one scoreboard entry register {vld, ld, addr}.
// Ports:
//   clk, rst (async active-low)
//   hold   : keep current contents (pipeline frozen)
//   clear  : load an invalid entry (bubble / flush)
//   load   : capture d_* when neither hold nor clear is active
//   d_*    : incoming entry,  q_* : stored entry
module hz_sb_stage
    import hazard_fwd_unit_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                clear,
    input  logic                load,
    input  logic [SB_VLD_W-1:0] d_vld,
    input  logic [SB_LD_W-1:0]  d_ld,
    input  logic [RA_W-1:0]     d_addr,
    output logic [SB_VLD_W-1:0] q_vld,
    output logic [SB_LD_W-1:0]  q_ld,
    output logic [RA_W-1:0]     q_addr
);

    // NOTE: state registers use non-blocking assignments with the async reset
    // in the sensitivity list, so every entry reads as invalid the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_vld  <= '0;
            q_ld   <= '0;
            q_addr <= '0;
        end else if (!hold) begin
            if (clear) begin
                q_vld  <= '0;
                q_ld   <= '0;
                q_addr <= '0;
            end else if (load) begin
                q_vld  <= d_vld;
                q_ld   <= d_ld;
                q_addr <= d_addr;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard/forwarding controller for a 5-stage pipeline.
// Inputs : ID-stage instruction info (id_*), taken branch from EX, data-memory busy.
// Outputs: pc_hold / id_ex_bubble / if_id_flush / pipe_freeze (combinational),
//          fwd_a_sel / fwd_b_sel (registered, aligned to the instruction in EX),
//          stall_cnt (saturating count of pc_hold cycles), state (RUN/FLUSH/FREEZE).
// Priority each cycle: mem_busy > flush > load-use > normal advance.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_wr_addr,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    // ---------------- scoreboard: EX, MEM, WB ----------------
    logic            sb_vld  [SB_DEPTH];
    logic            sb_ld   [SB_DEPTH];
    logic [RA_W-1:0] sb_addr [SB_DEPTH];
    logic            in_vld  [SB_DEPTH];
    logic            in_ld   [SB_DEPTH];
    logic [RA_W-1:0] in_addr [SB_DEPTH];

    logic flushing;
    logic ld_use;
    logic squash;

    // The EX slot takes the ID instruction; deeper slots shift. r0 never becomes valid.
    always_comb begin
        in_vld[SB_EX]  = id_valid & id_wr_en & (id_wr_addr != '0);
        in_ld[SB_EX]   = id_is_load;
        in_addr[SB_EX] = id_wr_addr;
        for (int i = 1; i < SB_DEPTH; i++) begin
            in_vld[i]  = sb_vld[i-1];
            in_ld[i]   = sb_ld[i-1];
            in_addr[i] = sb_addr[i-1];
        end
    end

    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_sb
        hz_sb_stage #(.RA_W(RA_W)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .hold   (mem_busy),
            .clear  ((i == SB_EX) ? squash : 1'b0),
            .load   (1'b1),
            .d_vld  (in_vld[i]),
            .d_ld   (in_ld[i]),
            .d_addr (in_addr[i]),
            .q_vld  (sb_vld[i]),
            .q_ld   (sb_ld[i]),
            .q_addr (sb_addr[i])
        );
    end

    // ---------------- FSM state register ----------------
    hz_state_e               state_q, state_d;
    hz_state_e               resume_q, resume_d;   // context to return to after FREEZE
    hz_state_e               ctx;                  // effective RUN/FLUSH context
    logic [FLUSH_CNT_W-1:0]  fcnt_q, fcnt_d;       // FLUSH cycles left, including current

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            resume_q <= ST_RUN;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // ---------------- FSM next state ----------------
    // NOTE: every variable driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        fcnt_d   = fcnt_q;
        if (mem_busy) begin
            state_d  = ST_FREEZE;
            resume_d = ctx;
        end else if (ex_br_taken) begin
            if (FLUSH_CYC > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FLUSH_CNT_W'(FLUSH_CYC - 1);
            end else begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        end else if (ctx == ST_FLUSH) begin
            if (fcnt_q <= FLUSH_CNT_W'(1)) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                state_d = ST_FLUSH;
                fcnt_d  = fcnt_q - FLUSH_CNT_W'(1);
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // ---------------- FSM / hazard outputs ----------------
    assign ctx      = (state_q == ST_FREEZE) ? resume_q : state_q;
    assign flushing = ex_br_taken | (ctx == ST_FLUSH);
    assign ld_use   = id_valid & sb_vld[SB_EX] & sb_ld[SB_EX] &
                      ((id_use_rs & (id_rs == sb_addr[SB_EX])) |
                       (id_use_rt & (id_rt == sb_addr[SB_EX])));
    assign squash   = flushing | ld_use;

    // Gating with rst forces every combinational output low while reset is held.
    assign pipe_freeze  = rst & mem_busy;
    assign if_id_flush  = rst & ~mem_busy & flushing;
    assign id_ex_bubble = rst & ~mem_busy & ~flushing & ld_use;
    assign pc_hold      = rst & (mem_busy | (~flushing & ld_use));
    assign state        = state_q;

    // ---------------- forwarding selects ----------------
    // The entry now in EX will be in MEM when the ID instruction reaches EX, and the
    // MEM entry will be in WB. A load in EX is skipped: the load-use stall covers it.
    function automatic fwd_sel_e pick_fwd(input logic [RA_W-1:0] src);
        if (sb_vld[SB_EX] && !sb_ld[SB_EX] && (sb_addr[SB_EX] == src)) return FWD_MEM;
        if (sb_vld[SB_MEM] && (sb_addr[SB_MEM] == src)) return FWD_WB;
        return FWD_RF;
    endfunction

    fwd_sel_e sel_a_q, sel_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else if (!mem_busy) begin
            if (squash) begin
                sel_a_q <= FWD_RF;
                sel_b_q <= FWD_RF;
            end else begin
                sel_a_q <= pick_fwd(id_rs);
                sel_b_q <= pick_fwd(id_rt);
            end
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;

    // ---------------- saturating stall counter ----------------
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
